// File: rtl/sopc_compteur_pkg.sv
// rtl/sopc_compteur_pkg.sv - shared defaults and read-owner encoding for the RAM arbiter
package sopc_compteur_pkg;

  localparam int ADDR_W_DEF    = 13;
  localparam int DEPTH_DEF     = 5120;
  localparam int MAX_BURST_DEF = 4;

  // Which master owns the read data returning from the RAM this cycle
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_t;

  // Width needed to hold a burst count in the range 0..max_burst
  function automatic int cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/sopc_rr_arb2.sv
// rtl/sopc_rr_arb2.sv - two-way round-robin arbiter with a consecutive-grant limit
module sopc_rr_arb2
  import sopc_compteur_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int CNT_W     = cnt_width(MAX_BURST)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [1:0]       i_req,
  output logic [1:0]       o_gnt,
  output logic             o_last_grant,
  output logic [CNT_W-1:0] o_burst_cnt
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  logic             r_last_grant;
  logic [CNT_W-1:0] r_burst_cnt;
  logic [1:0]       w_gnt;
  logic             w_keep;
  logic             w_winner;

  // Sole requester wins outright; on contention the burst owner keeps the port until its budget is spent
  always_comb begin
    w_gnt  = 2'b00;
    w_keep = (r_burst_cnt != '0) && (r_burst_cnt < MAX_CNT);
    if (!i_reset) begin
      if (i_req == 2'b11) begin
        if (w_keep ? r_last_grant : ~r_last_grant) begin
          w_gnt = 2'b10;
        end else begin
          w_gnt = 2'b01;
        end
      end else begin
        w_gnt = i_req;
      end
    end
  end

  assign w_winner = w_gnt[1];

  // Remember the latest grantee and count its consecutive grants; an idle cycle ends the burst
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_last_grant <= 1'b1;
      r_burst_cnt  <= '0;
    end else if (w_gnt == 2'b00) begin
      r_burst_cnt <= '0;
    end else begin
      r_last_grant <= w_winner;
      if ((r_burst_cnt != '0) && (w_winner == r_last_grant)) begin
        if (r_burst_cnt != MAX_CNT) begin
          r_burst_cnt <= r_burst_cnt + CNT_W'(1);
        end
      end else begin
        r_burst_cnt <= CNT_W'(1);
      end
    end
  end

  assign o_gnt        = w_gnt;
  assign o_last_grant = r_last_grant;
  assign o_burst_cnt  = r_burst_cnt;

endmodule

// File: rtl/sopc_compteur_ram_arbiter.sv
// rtl/sopc_compteur_ram_arbiter.sv - two-master arbiter in front of a single-port on-chip RAM
module sopc_compteur_ram_arbiter
  import sopc_compteur_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [3:0]        m0_byteenable,
  input  logic [31:0]       m0_writedata,
  output logic              m0_waitrequest,
  output logic [31:0]       m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [3:0]        m1_byteenable,
  input  logic [31:0]       m1_writedata,
  output logic              m1_waitrequest,
  output logic [31:0]       m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] ram_address,
  output logic [3:0]        ram_byteenable,
  output logic [31:0]       ram_writedata,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic              ram_clken,
  input  logic [31:0]       ram_readdata,
  output logic              oor_error
);

  localparam int                CNT_W   = cnt_width(MAX_BURST);
  localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_BURST);
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic              w_last_grant;
  logic [CNT_W-1:0]  w_burst_cnt;
  logic              w_any;
  logic              w_sel;
  logic [ADDR_W-1:0] w_addr;
  logic [3:0]        w_be;
  logic [31:0]       w_wd;
  logic              w_is_wr;
  logic              w_oor;
  logic [31:0]       w_rd_data;

  owner_t            r_rd_owner;
  logic              r_rd_oor;
  logic              r_oor_error;
  logic [ADDR_W-1:0] r_hold_addr;
  logic [3:0]        r_hold_be;
  logic [31:0]       r_hold_wd;

  // A simultaneous read and write is a protocol error and is served as a write
  assign w_req = {m1_read | m1_write, m0_read | m0_write};

  sopc_rr_arb2 #(
    .MAX_BURST (MAX_BURST),
    .CNT_W     (CNT_W)
  ) u_arb (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_req        (w_req),
    .o_gnt        (w_gnt),
    .o_last_grant (w_last_grant),
    .o_burst_cnt  (w_burst_cnt)
  );

  assign w_any   = |w_gnt;
  assign w_sel   = w_gnt[1];
  assign w_addr  = w_sel ? m1_address    : m0_address;
  assign w_be    = w_sel ? m1_byteenable : m0_byteenable;
  assign w_wd    = w_sel ? m1_writedata  : m0_writedata;
  assign w_is_wr = w_sel ? m1_write      : m0_write;
  assign w_oor   = ({1'b0, w_addr} >= DEPTH_L);

  // Out-of-range accesses are accepted but never reach the RAM
  assign ram_chipselect = w_any & ~w_oor;
  assign ram_write      = w_any & ~w_oor & w_is_wr;
  assign ram_clken      = ~reset;
  assign ram_address    = w_any ? w_addr : r_hold_addr;
  assign ram_byteenable = w_any ? w_be   : r_hold_be;
  assign ram_writedata  = w_any ? w_wd   : r_hold_wd;

  assign m0_waitrequest = ~w_gnt[0];
  assign m1_waitrequest = ~w_gnt[1];

  // Keep the RAM-side address and data stable across idle cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold_addr <= '0;
      r_hold_be   <= '0;
      r_hold_wd   <= '0;
    end else if (w_any) begin
      r_hold_addr <= w_addr;
      r_hold_be   <= w_be;
      r_hold_wd   <= w_wd;
    end
  end

  // Tag each accepted read with its owner so the data returns to the right master next cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_owner  <= OWN_NONE;
      r_rd_oor    <= 1'b0;
      r_oor_error <= 1'b0;
    end else begin
      if (w_any && !w_is_wr) begin
        r_rd_owner <= w_sel ? OWN_M1 : OWN_M0;
      end else begin
        r_rd_owner <= OWN_NONE;
      end
      r_rd_oor <= w_oor;
      if (w_any && w_oor) begin
        r_oor_error <= 1'b1;
      end
    end
  end

  assign w_rd_data        = r_rd_oor ? 32'd0 : ram_readdata;
  assign m0_readdatavalid = ~reset & (r_rd_owner == OWN_M0);
  assign m1_readdatavalid = ~reset & (r_rd_owner == OWN_M1);
  assign m0_readdata      = m0_readdatavalid ? w_rd_data : 32'd0;
  assign m1_readdata      = m1_readdatavalid ? w_rd_data : 32'd0;
  assign oor_error        = r_oor_error & ~reset;

  // The returning read's owner is always the master the arbiter granted last
  a_owner_matches_last : assert property (@(posedge clk) disable iff (reset)
    (r_rd_owner != OWN_NONE) |-> (w_last_grant == (r_rd_owner == OWN_M1)));

  // The burst counter never runs past its limit
  a_burst_bounded : assert property (@(posedge clk) disable iff (reset)
    (w_burst_cnt <= MAX_CNT));

endmodule

// File: tb/tb_sopc_compteur_ram_arbiter.sv
// tb/tb_sopc_compteur_ram_arbiter.sv - self-checking bench for the two-master RAM arbiter
module tb_sopc_compteur_ram_arbiter;

  localparam int ADDR_W    = 13;
  localparam int DEPTH     = 5120;
  localparam int MAX_BURST = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic              d_rd   [2];
  logic              d_wr   [2];
  logic [ADDR_W-1:0] d_addr [2];
  logic [3:0]        d_be   [2];
  logic [31:0]       d_wd   [2];

  logic              m0_waitrequest, m1_waitrequest;
  logic [31:0]       m0_readdata, m1_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic [ADDR_W-1:0] ram_address;
  logic [3:0]        ram_byteenable;
  logic [31:0]       ram_writedata;
  logic              ram_chipselect, ram_write, ram_clken;
  logic [31:0]       ram_readdata;
  logic              oor_error;

  sopc_compteur_ram_arbiter #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_address(d_addr[0]), .m0_read(d_rd[0]), .m0_write(d_wr[0]),
    .m0_byteenable(d_be[0]), .m0_writedata(d_wd[0]),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(d_addr[1]), .m1_read(d_rd[1]), .m1_write(d_wr[1]),
    .m1_byteenable(d_be[1]), .m1_writedata(d_wd[1]),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable), .ram_writedata(ram_writedata),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write), .ram_clken(ram_clken),
    .ram_readdata(ram_readdata), .oor_error(oor_error)
  );

  // Environment RAM: registered read, byte-lane write
  logic [31:0] ram_mem [0:8191];
  logic [31:0] ram_rdq;
  logic        init_en;
  logic [31:0] seed;
  assign ram_readdata = ram_rdq;

  always @(posedge clk) begin
    if (init_en) begin
      for (int i = 0; i < 8192; i++) ram_mem[i] <= (32'(i) * 32'h9E3779B1) ^ seed;
    end else if (ram_clken && ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) ram_mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
      end else begin
        ram_rdq <= ram_mem[ram_address];
      end
    end
  end

  // Reference model state
  logic [31:0]       ref_mem [0:8191];
  int                m_last, m_run, pend;
  logic [31:0]       pend_data;
  logic              m_oor;
  logic [ADDR_W-1:0] m_hold;
  logic              m_hold_valid;
  int                errors = 0;
  int                checks = 0;

  function automatic int arb_pick();
    logic q0, q1;
    q0 = d_rd[0] | d_wr[0];
    q1 = d_rd[1] | d_wr[1];
    if (q0 && q1) return (m_run > 0 && m_run < MAX_BURST) ? m_last : 1 - m_last;
    if (q0) return 0;
    if (q1) return 1;
    return -1;
  endfunction

  task automatic model_commit();
    int g;
    if (reset) begin
      m_last = 1; m_run = 0; pend = -1; m_oor = 1'b0; m_hold_valid = 1'b0;
      return;
    end
    g = arb_pick();
    pend = -1;
    if (g < 0) begin
      m_run = 0;
      return;
    end
    if (m_run > 0 && g == m_last) m_run = (m_run < MAX_BURST) ? m_run + 1 : MAX_BURST;
    else m_run = 1;
    m_last = g;
    m_hold = d_addr[g];
    m_hold_valid = 1'b1;
    if (int'(d_addr[g]) >= DEPTH) m_oor = 1'b1;
    if (d_wr[g]) begin
      if (int'(d_addr[g]) < DEPTH)
        for (int b = 0; b < 4; b++)
          if (d_be[g][b]) ref_mem[d_addr[g]][8*b +: 8] = d_wd[g][8*b +: 8];
    end else begin
      pend = g;
      pend_data = (int'(d_addr[g]) < DEPTH) ? ref_mem[d_addr[g]] : 32'd0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle();
    for (int n = 0; n < 2; n++) begin
      d_rd[n] = 1'b0; d_wr[n] = 1'b0;
    end
  endtask

  task automatic drive(input int n, input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                       input logic [3:0] be, input logic [31:0] wd);
    d_rd[n] = rd; d_wr[n] = wr; d_addr[n] = a; d_be[n] = be; d_wd[n] = wd;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 1'b1, 1'b0, 13'h0010, 4'hF, 32'd0);
    drive(1, 1'b0, 1'b1, 13'h0020, 4'hF, 32'h1234);
    @(negedge clk);
    checks++;
    if ({m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid,
         ram_chipselect, ram_write, ram_clken, oor_error} !== 8'b1100_0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 11000000", {m0_waitrequest, m1_waitrequest,
               m0_readdatavalid, m1_readdatavalid, ram_chipselect, ram_write, ram_clken, oor_error});
    end
    checks++;
    if (m0_readdata !== 32'd0 || m1_readdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_rdata: got %h/%h want 0/0", m0_readdata, m1_readdata);
    end
    tick();
    reset = 1'b0;
    idle();
    @(negedge clk);
    checks++;
    if (ram_clken !== 1'b1) begin
      errors++;
      $display("FAIL clken_after_reset: got %b want 1", ram_clken);
    end
    tick();
  endtask

  task automatic test_single_read();
    drive(0, 1'b1, 1'b0, 13'h0010, 4'hF, 32'd0);
    @(negedge clk);
    checks++;
    if ({m0_waitrequest, ram_chipselect, ram_write} !== 3'b010 || ram_address !== 13'h0010) begin
      errors++;
      $display("FAIL single_read_issue: got wr=%b cs=%b we=%b addr=%h want 0 1 0 0010",
               m0_waitrequest, ram_chipselect, ram_write, ram_address);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (m0_readdatavalid !== 1'b1 || m0_readdata !== ref_mem[16]) begin
      errors++;
      $display("FAIL single_read_data: got v=%b d=%h want 1 %h", m0_readdatavalid, m0_readdata, ref_mem[16]);
    end
    checks++;
    if (m1_readdatavalid !== 1'b0 || m1_readdata !== 32'd0) begin
      errors++;
      $display("FAIL single_read_m1_idle: got v=%b d=%h want 0 0", m1_readdatavalid, m1_readdata);
    end
    tick();
  endtask

  task automatic test_burst();
    logic [ADDR_W-1:0] a0, a1;
    int g;
    do_reset();
    for (int k = 0; k < 24; k++) begin
      a0 = ADDR_W'($urandom_range(0, DEPTH - 1));
      a1 = ADDR_W'($urandom_range(0, DEPTH - 1));
      drive(0, 1'b0, 1'b1, a0, 4'hF, $urandom);
      drive(1, 1'b0, 1'b1, a1, 4'hF, $urandom);
      g = (k / 4) % 2;
      @(negedge clk);
      checks++;
      if ({m0_waitrequest, m1_waitrequest} !== ((g == 0) ? 2'b01 : 2'b10) || ram_write !== 1'b1 ||
          ram_address !== ((g == 0) ? a0 : a1)) begin
        errors++;
        $display("FAIL burst_grant k=%0d: got wr=%b%b we=%b addr=%h want master %0d", k,
                 m0_waitrequest, m1_waitrequest, ram_write, ram_address, g);
      end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_byteenable();
    logic [31:0] prior;
    prior = ref_mem[256];
    drive(0, 1'b0, 1'b1, 13'h0100, 4'h3, 32'hDEADBEEF);
    @(negedge clk);
    checks++;
    if ({m0_waitrequest, ram_chipselect, ram_write, ram_byteenable} !== 7'b0_1_1_0011 ||
        ram_writedata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL be_write_issue: got wr=%b cs=%b we=%b be=%h wd=%h", m0_waitrequest,
               ram_chipselect, ram_write, ram_byteenable, ram_writedata);
    end
    tick();
    idle();
    drive(1, 1'b1, 1'b0, 13'h0100, 4'hF, 32'd0);
    @(negedge clk);
    checks++;
    if (m1_waitrequest !== 1'b0) begin
      errors++;
      $display("FAIL be_read_accept: got %b want 0", m1_waitrequest);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (m1_readdatavalid !== 1'b1 || m1_readdata !== {prior[31:16], 16'hBEEF}) begin
      errors++;
      $display("FAIL be_read_data: got v=%b d=%h want 1 %h", m1_readdatavalid, m1_readdata,
               {prior[31:16], 16'hBEEF});
    end
    tick();
  endtask

  task automatic test_oor();
    do_reset();
    drive(1, 1'b1, 1'b0, 13'h1400, 4'hF, 32'd0);
    @(negedge clk);
    checks++;
    if ({m1_waitrequest, ram_chipselect, oor_error} !== 3'b000) begin
      errors++;
      $display("FAIL oor_read_issue: got wr=%b cs=%b oor=%b want 000", m1_waitrequest, ram_chipselect, oor_error);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if ({m1_readdatavalid, oor_error} !== 2'b11 || m1_readdata !== 32'd0) begin
      errors++;
      $display("FAIL oor_read_return: got v=%b oor=%b d=%h want 1 1 0", m1_readdatavalid, oor_error, m1_readdata);
    end
    repeat (6) tick();
    @(negedge clk);
    checks++;
    if (oor_error !== 1'b1) begin
      errors++;
      $display("FAIL oor_sticky: got %b want 1", oor_error);
    end
    tick();
    drive(0, 1'b0, 1'b1, 13'h1FFF, 4'hF, 32'h55AA55AA);
    @(negedge clk);
    checks++;
    if ({m0_waitrequest, ram_chipselect, ram_write} !== 3'b000) begin
      errors++;
      $display("FAIL oor_write_drop: got wr=%b cs=%b we=%b want 000", m0_waitrequest, ram_chipselect, ram_write);
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_alternating();
    int          mst [3];
    logic [12:0] adr [3];
    mst = '{0, 1, 0};
    adr = '{13'h0001, 13'h0002, 13'h0003};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      idle();
      if (i < 3) drive(mst[i], 1'b1, 1'b0, adr[i], 4'hF, 32'd0);
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if ({m0_readdatavalid, m1_readdatavalid} !== ((mst[i-1] == 0) ? 2'b10 : 2'b01) ||
            ((mst[i-1] == 0) ? m0_readdata : m1_readdata) !== ref_mem[adr[i-1]]) begin
          errors++;
          $display("FAIL alt_read %0d: got v=%b%b d0=%h d1=%h want master %0d data %h", i,
                   m0_readdatavalid, m1_readdatavalid, m0_readdata, m1_readdata, mst[i-1], ref_mem[adr[i-1]]);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_pending();
    drive(0, 1'b0, 1'b1, 13'h1FFF, 4'hF, 32'd0);
    tick();
    idle();
    drive(0, 1'b1, 1'b0, 13'h0020, 4'hF, 32'd0);
    tick();
    idle();
    reset = 1'b1;
    drive(1, 1'b1, 1'b0, 13'h0030, 4'hF, 32'd0);
    @(negedge clk);
    checks++;
    if ({m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid,
         ram_chipselect, ram_write, ram_clken, oor_error} !== 8'b1100_0000 ||
        m0_readdata !== 32'd0 || m1_readdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_pending_outputs: got %b d0=%h d1=%h want 11000000 0 0", {m0_waitrequest,
               m1_waitrequest, m0_readdatavalid, m1_readdatavalid, ram_chipselect, ram_write,
               ram_clken, oor_error}, m0_readdata, m1_readdata);
    end
    tick();
    reset = 1'b0;
    idle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({m0_readdatavalid, m1_readdatavalid, oor_error} !== 3'b000) begin
        errors++;
        $display("FAIL reset_pending_after %0d: got v=%b%b oor=%b want 000", i,
                 m0_readdatavalid, m1_readdatavalid, oor_error);
      end
      tick();
    end
  endtask

  task automatic test_random();
    int   g, op;
    logic exp_cs, exp_we;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int n = 0; n < 2; n++) begin
        op = $urandom_range(0, 5);
        d_rd[n] = (op == 2 || op == 3 || op == 5);
        d_wr[n] = (op == 4 || op == 5);
        d_addr[n] = ($urandom_range(0, 9) == 0) ? ADDR_W'($urandom_range(DEPTH, 8191))
                                                : ADDR_W'($urandom_range(0, DEPTH - 1));
        d_be[n] = 4'($urandom_range(0, 15));
        d_wd[n] = $urandom;
      end
      g = arb_pick();
      exp_cs = (g >= 0) && (int'(d_addr[(g < 0) ? 0 : g]) < DEPTH);
      exp_we = exp_cs && d_wr[(g < 0) ? 0 : g];
      @(negedge clk);
      checks++;
      if ({m0_waitrequest, m1_waitrequest} !== {g != 0, g != 1}) begin
        errors++;
        $display("FAIL rand_grant c=%0d: got wr=%b%b want grant %0d", c, m0_waitrequest, m1_waitrequest, g);
      end
      checks++;
      if ({ram_chipselect, ram_write} !== {exp_cs, exp_we}) begin
        errors++;
        $display("FAIL rand_strobe c=%0d: got cs=%b we=%b want %b %b", c, ram_chipselect, ram_write, exp_cs, exp_we);
      end
      if (g >= 0) begin
        checks++;
        if (ram_address !== d_addr[g] || (exp_we && (ram_writedata !== d_wd[g] || ram_byteenable !== d_be[g]))) begin
          errors++;
          $display("FAIL rand_ram_drive c=%0d: got a=%h wd=%h be=%h want a=%h wd=%h be=%h", c,
                   ram_address, ram_writedata, ram_byteenable, d_addr[g], d_wd[g], d_be[g]);
        end
      end else if (m_hold_valid) begin
        checks++;
        if (ram_address !== m_hold) begin
          errors++;
          $display("FAIL rand_hold c=%0d: got a=%h want %h", c, ram_address, m_hold);
        end
      end
      checks++;
      if ({m0_readdatavalid, m1_readdatavalid} !== {pend == 0, pend == 1} ||
          m0_readdata !== ((pend == 0) ? pend_data : 32'd0) ||
          m1_readdata !== ((pend == 1) ? pend_data : 32'd0)) begin
        errors++;
        $display("FAIL rand_rdata c=%0d: got v=%b%b d0=%h d1=%h want owner %0d data %h", c,
                 m0_readdatavalid, m1_readdatavalid, m0_readdata, m1_readdata, pend, pend_data);
      end
      checks++;
      if (oor_error !== m_oor) begin
        errors++;
        $display("FAIL rand_oor c=%0d: got %b want %b", c, oor_error, m_oor);
      end
      tick();
    end
    idle();
    tick();
  endtask

  initial begin
    seed = $urandom;
    for (int i = 0; i < 8192; i++) ref_mem[i] = (32'(i) * 32'h9E3779B1) ^ seed;
    for (int n = 0; n < 2; n++) drive(n, 1'b0, 1'b0, '0, 4'h0, 32'd0);
    init_en = 1'b1;
    tick();
    init_en = 1'b0;
    test_reset();
    test_single_read();
    test_burst();
    test_byteenable();
    test_oor();
    test_alternating();
    test_reset_pending();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
